aes_serial_io: RTL

AES_SERIAL_IO -- requirements
Module: aes_serial_io

---
 rtl/aes_serial_io.sv | 118 +++++++++++
 1 files changed

// File: rtl/aes_serial_io.sv
// Serial front end for an AES core. A bit-serial input is assembled into a
// block for the core, and result blocks are shifted back out bit-serially.
module aes_serial_io #(
  parameter int DATA_W    = 128,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              EN,
  input  logic              DIN,
  input  logic              EN_DEC,
  output logic [DATA_W-1:0] core_in_data,
  output logic              core_in_dec,
  output logic              core_in_valid,
  input  logic              core_in_ready,
  input  logic [DATA_W-1:0] core_out_data,
  input  logic              core_out_valid,
  output logic              core_out_ready,
  output logic              DOUT,
  output logic              OUT_VAL,
  output logic              OVR
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic {S_IDLE, S_SHIFT} out_state_t;

  logic [CW-1:0]     bit_cnt;
  logic [CW-1:0]     in_idx;
  logic [CW-1:0]     out_cnt;
  logic [CW-1:0]     out_idx;
  logic [DATA_W-1:0] asm_data;
  logic [DATA_W-1:0] asm_full;
  logic [DATA_W-1:0] out_data;
  logic              dec_lat;
  logic              in_xfer;
  logic              blk_done;
  logic              out_load;
  out_state_t        out_state;

  // asm_full is the block including the bit sampled this edge, so a block
  // completing on the last count can go straight into the holding register.
  always_comb begin
    in_idx   = (MSB_FIRST != 0) ? LAST - bit_cnt : bit_cnt;
    out_idx  = (MSB_FIRST != 0) ? LAST - out_cnt : out_cnt;
    asm_full = asm_data;
    asm_full[in_idx] = DIN;
  end

  assign in_xfer        = core_in_valid & core_in_ready;
  assign blk_done       = EN && (bit_cnt == LAST);
  assign OUT_VAL        = (out_state == S_SHIFT);
  assign core_out_ready = (out_state == S_IDLE) || (out_cnt == LAST);
  assign out_load       = core_out_valid & core_out_ready;
  assign DOUT           = OUT_VAL & out_data[out_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt       <= '0;
      asm_data      <= '0;
      dec_lat       <= 1'b0;
      core_in_data  <= '0;
      core_in_dec   <= 1'b0;
      core_in_valid <= 1'b0;
      OVR           <= 1'b0;
    end else begin
      if (EN) begin
        asm_data <= asm_full;
        bit_cnt  <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
        if (bit_cnt == '0)
          dec_lat <= EN_DEC;
      end
      if (blk_done && (!core_in_valid || in_xfer)) begin
        core_in_data  <= asm_full;
        core_in_dec   <= dec_lat;
        core_in_valid <= 1'b1;
      end else begin
        if (in_xfer)
          core_in_valid <= 1'b0;
        // Holding register is occupied and not draining: drop the new block.
        if (blk_done)
          OVR <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_state <= S_IDLE;
      out_cnt   <= '0;
      out_data  <= '0;
    end else begin
      case (out_state)
        S_IDLE: begin
          if (out_load) begin
            out_data  <= core_out_data;
            out_cnt   <= '0;
            out_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (out_cnt == LAST) begin
            out_cnt <= '0;
            if (out_load)
              out_data <= core_out_data;
            else
              out_state <= S_IDLE;
          end else begin
            out_cnt <= out_cnt + CW'(1);
          end
        end
        default: out_state <= S_IDLE;
      endcase
    end
  end

endmodule
